// File: rtl/rom_boot_loader_pkg.sv
// rom_boot_loader_pkg
//   Shared types and helpers for the ROM boot loader.
//   - ld_state_e     : loader FSM states (LEN, DATA, WRITE, DONE, RUN)
//   - MEM_W          : width of the ROM / CPU data and address buses
//   - ZERO_WORD      : idle value driven on data buses
//   - word_byte_addr : byte address of a word index relative to a base
package rom_boot_loader_pkg;

    localparam int unsigned MEM_W     = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        LD_LEN   = 3'd0,
        LD_DATA  = 3'd1,
        LD_WRITE = 3'd2,
        LD_DONE  = 3'd3,
        LD_RUN   = 3'd4
    } ld_state_e;

    // Word index to byte address; the shift drops the top bits so the sum wraps at 32 bits.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] index);
        return base + {index[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/rom_boot_loader_byte_packer.sv
// rom_boot_loader_byte_packer
//   Packs a little-endian byte stream into 32-bit words. The first byte of a
//   group lands in [7:0], the fourth in [31:24].
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     clear_i       : restart packing at byte lane 0 and zero the word
//     byte_fire_i   : a byte transfers on this clock edge
//     byte_data_i   : the byte being transferred
//     word_o        : word including the byte transferring this cycle
//     word_valid_o  : high in the cycle the fourth byte of a group transfers
module rom_boot_loader_byte_packer
    import rom_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_fire_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // Byte-lane counter and assembly register update.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            word_d = ZERO_WORD;
        end else if (byte_fire_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    word_d[7:0]   = byte_data_i;
                2'd1:    word_d[15:8]  = byte_data_i;
                2'd2:    word_d[23:16] = byte_data_i;
                default: word_d[31:24] = byte_data_i;
            endcase
        end else begin
            cnt_d  = cnt_q;
            word_d = word_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= ZERO_WORD;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // word_o is the next-state value so the FSM can capture the length on the
    // same edge as the fourth byte; outside a transfer it equals the register.
    assign word_o       = word_d;
    assign word_valid_o = byte_fire_i & ~clear_i & (cnt_q == 2'd3);

endmodule

// File: rtl/rom_boot_loader.sv
// rom_boot_loader
//   Boot-time ROM loader. Holds the CPU in reset, receives a length-prefixed
//   little-endian byte stream, writes the packed words into the ROM, then
//   hands the ROM read path to the CPU fetch port and releases the CPU.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     load_req_i                  : restart a load (honoured only in RUN)
//     byte_valid_i/_data_i        : byte source; byte_ready_o accepts it
//     cpu_ce_i/_addr_i/cpu_data_o : CPU fetch port (combinational in RUN)
//     cpu_rst_o                   : CPU reset, high except in RUN
//     rom_we_o/_addr_o/_data_o    : ROM write/address port; rom_data_i read data
//     busy_o, done_o, err_o       : status (err_o: length exceeded ROM_WORDS)
//     words_o                     : words written in the last/current load
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter int unsigned ROM_WORDS = 24576,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_rst_o,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_data_o,
    input  logic [31:0] rom_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] words_o
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

    ld_state_e   state_q, state_d;
    logic [31:0] index_q, index_d;
    logic [31:0] len_q,   len_d;
    logic [31:0] words_q, words_d;
    logic        err_q,   err_d;

    logic        byte_fire_s;
    logic        packer_clear_s;
    logic [31:0] word_s;
    logic        word_valid_s;
    logic [31:0] index_inc_s;
    logic        in_range_s;

    assign byte_fire_s = byte_valid_i & byte_ready_o;
    assign index_inc_s = index_q + 32'd1;
    assign in_range_s  = (index_q < ROM_LIMIT);

    rom_boot_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (packer_clear_s),
        .byte_fire_i  (byte_fire_s),
        .byte_data_i  (byte_data_i),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // State and load-progress registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_LEN;
            index_q <= 32'd0;
            len_q   <= 32'd0;
            words_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    // Next-state and load-progress logic.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        len_d          = len_q;
        words_d        = words_q;
        err_d          = err_q;
        packer_clear_s = 1'b0;
        case (state_q)
            LD_LEN: begin
                if (word_valid_s) begin
                    len_d   = word_s;
                    err_d   = err_q | (word_s > ROM_LIMIT);
                    state_d = (word_s == 32'd0) ? LD_DONE : LD_DATA;
                end else begin
                    state_d = LD_LEN;
                end
            end
            LD_DATA: begin
                if (word_valid_s) begin
                    state_d = LD_WRITE;
                end else begin
                    state_d = LD_DATA;
                end
            end
            LD_WRITE: begin
                // Words past the ROM end are consumed but not counted.
                if (in_range_s) begin
                    words_d = words_q + 32'd1;
                end else begin
                    words_d = words_q;
                end
                index_d = index_inc_s;
                state_d = (index_inc_s == len_q) ? LD_DONE : LD_DATA;
            end
            LD_DONE: begin
                state_d = LD_RUN;
            end
            LD_RUN: begin
                if (load_req_i) begin
                    state_d        = LD_LEN;
                    index_d        = 32'd0;
                    len_d          = 32'd0;
                    words_d        = 32'd0;
                    err_d          = 1'b0;
                    packer_clear_s = 1'b1;
                end else begin
                    state_d = LD_RUN;
                end
            end
            default: begin
                state_d = LD_LEN;
            end
        endcase
    end

    // Output decode; in RUN the ROM read path is a straight combinational
    // pass-through so instruction fetch sees no extra latency.
    always_comb begin
        byte_ready_o = 1'b0;
        cpu_rst_o    = 1'b1;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        rom_we_o     = 1'b0;
        rom_addr_o   = word_byte_addr(BASE_ADDR, index_q);
        rom_data_o   = ZERO_WORD;
        cpu_data_o   = ZERO_WORD;
        case (state_q)
            LD_LEN, LD_DATA: begin
                byte_ready_o = 1'b1;
            end
            LD_WRITE: begin
                rom_we_o   = in_range_s;
                rom_data_o = word_s;
            end
            LD_DONE: begin
                done_o = 1'b1;
            end
            LD_RUN: begin
                cpu_rst_o  = 1'b0;
                busy_o     = 1'b0;
                rom_addr_o = cpu_addr_i;
                cpu_data_o = cpu_ce_i ? rom_data_i : ZERO_WORD;
            end
            default: begin
                byte_ready_o = 1'b0;
            end
        endcase
    end

    assign err_o   = err_q;
    assign words_o = words_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
module tb_rom_boot_loader;

    localparam int unsigned ROM_WORDS = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        load_req_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        cpu_rst_o;
    logic        rom_we_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_o;
    logic [31:0] rom_data_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] words_o;

    rom_boot_loader #(.ROM_WORDS(ROM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req_i   (load_req_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .cpu_ce_i     (cpu_ce_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .rom_we_o     (rom_we_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_o   (rom_data_o),
        .rom_data_i   (rom_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_o      (words_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM instance stand-in: combinational read, synchronous write.
    logic [31:0] rom_mem [0:ROM_WORDS-1];
    logic [31:0] rom_off;
    logic [31:0] rom_idx;
    assign rom_off = rom_addr_o - BASE_ADDR;
    assign rom_idx = rom_off >> 2;
    always_comb begin
        if (rom_off[1:0] == 2'b00 && rom_idx < ROM_WORDS) rom_data_i = rom_mem[rom_idx[1:0]];
        else rom_data_i = 32'h0;
    end
    always @(posedge clk) begin
        if (rom_we_o && rom_idx < ROM_WORDS) rom_mem[rom_idx[1:0]] <= rom_data_o;
    end

    // Reference model: expected ROM image and expected events.
    logic [31:0] model_mem [0:ROM_WORDS-1];
    logic [31:0] img_q [$];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] exp_words_q [$];
    logic        exp_err_q [$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a write or done.
    logic [31:0] mon_a, mon_d;
    logic        done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (rom_we_o) begin
                check("ready_in_write", {31'd0, byte_ready_o}, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    mon_a = exp_addr_q.pop_front();
                    mon_d = exp_data_q.pop_front();
                    check("wr_addr", rom_addr_o, mon_a);
                    check("wr_data", rom_data_o, mon_d);
                end
            end
            if (done_o) begin
                if (exp_words_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    check("done_words", words_o, exp_words_q.pop_front());
                    check("done_err", {31'd0, err_o}, {31'd0, exp_err_q.pop_front()});
                    check("cpu_rst_in_done", {31'd0, cpu_rst_o}, 32'd1);
                end
            end
            if (done_prev) check("cpu_rst_release", {31'd0, cpu_rst_o}, 32'd0);
            done_prev = done_o;
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            byte_valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        n = 0;
        while (!byte_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) fail_now("byte_ready_timeout");
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (busy_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) fail_now("run_timeout");
    endtask

    // Streams img_q as one image and records what the ROM should see.
    task automatic load_image(input int max_gap, input logic pulse_req);
        int n;
        logic [31:0] w;
        n = img_q.size();
        for (int i = 0; i < n; i++) begin
            if (i < ROM_WORDS) begin
                exp_addr_q.push_back(BASE_ADDR + 32'(4 * i));
                exp_data_q.push_back(img_q[i]);
                model_mem[i] = img_q[i];
            end
        end
        exp_words_q.push_back((n < ROM_WORDS) ? 32'(n) : 32'(ROM_WORDS));
        exp_err_q.push_back(n > ROM_WORDS);
        send_word(32'(n), max_gap);
        check("err_after_len", {31'd0, err_o}, (n > ROM_WORDS) ? 32'd1 : 32'd0);
        for (int i = 0; i < n; i++) begin
            w = img_q[i];
            for (int k = 0; k < 4; k++) begin
                load_req_i = (pulse_req && i == 0 && k == 1);
                send_byte(w[8*k +: 8], max_gap);
                load_req_i = 1'b0;
            end
        end
        byte_valid_i = 1'b0;
        wait_run();
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
        check("done_left", 32'(exp_words_q.size()), 32'd0);
    endtask

    task automatic reload();
        load_req_i = 1'b1;
        @(negedge clk);
        load_req_i = 1'b0;
        check("reload_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("reload_busy", {31'd0, busy_o}, 32'd1);
        check("reload_words", words_o, 32'd0);
        check("reload_err", {31'd0, err_o}, 32'd0);
    endtask

    task automatic fetch(input int idx);
        cpu_addr_i = BASE_ADDR + 32'(4 * idx);
        cpu_ce_i   = 1'b1;
        #1;
        check("fetch_data", cpu_data_o, model_mem[idx]);
        cpu_ce_i = 1'b0;
        #1;
        check("fetch_ce_off", cpu_data_o, 32'd0);
        @(negedge clk);
    endtask

    task automatic random_fetches();
        for (int i = 0; i < 3; i++) fetch(int'($urandom_range(ROM_WORDS - 1, 0)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < ROM_WORDS; i++) begin
            rom_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end
        rst = 1'b1; load_req_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
        cpu_ce_i = 1'b0; cpu_addr_i = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cpu_ce_i = 1'b1;
        cpu_addr_i = BASE_ADDR;
        #1;
        check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd1);
        check("rst_we", {31'd0, rom_we_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_words", words_o, 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'd0);
        check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
        check("rst_rom_addr", rom_addr_o, BASE_ADDR);
        cpu_ce_i = 1'b0;
        @(negedge clk);

        // Basic two-word load, continuous valid.
        img_q = '{32'h1234_5678, 32'hDEAD_BEEF};
        load_image(0, 1'b0);
        fetch(1);
        fetch(0);

        // Zero-length image.
        reload();
        img_q = '{};
        load_image(0, 1'b0);
        check("zero_err", {31'd0, err_o}, 32'd0);

        // Random images with random valid gaps.
        for (int t = 0; t < 5; t++) begin
            reload();
            n = int'($urandom_range(ROM_WORDS, 1));
            img_q = '{};
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            load_image(3, 1'b0);
            random_fetches();
        end

        // Overflow: six words into a four-word ROM.
        reload();
        img_q = '{};
        for (int i = 0; i < 6; i++) img_q.push_back($urandom);
        load_image(2, 1'b0);
        check("ovf_err_run", {31'd0, err_o}, 32'd1);
        random_fetches();

        // Reload one word; err_o cleared by reload().
        reload();
        img_q = '{32'hCAFE_BABE};
        load_image(0, 1'b0);
        fetch(0);

        // load_req_i during DATA is ignored.
        reload();
        img_q = '{$urandom, $urandom, $urandom};
        load_image(1, 1'b1);
        random_fetches();

        // Reset after one full word and two bytes of the next.
        reload();
        exp_addr_q.push_back(BASE_ADDR);
        exp_data_q.push_back(32'hA5A5_0001);
        model_mem[0] = 32'hA5A5_0001;
        send_word(32'd2, 0);
        send_word(32'hA5A5_0001, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        byte_valid_i = 1'b0;
        check("pre_rst_words", words_o, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("midrst_busy", {31'd0, busy_o}, 32'd1);
        check("midrst_words", words_o, 32'd0);
        check("midrst_ready", {31'd0, byte_ready_o}, 32'd1);
        check("midrst_writes_left", 32'(exp_addr_q.size()), 32'd0);
        @(negedge clk);
        img_q = '{$urandom, $urandom};
        load_image(2, 1'b0);
        fetch(0);
        fetch(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
Boot-time controller for the instruction ROM. After reset it holds the CPU in reset, receives a length-prefixed little-endian byte stream (e.g. from a UART receiver) and packs it into 32-bit words. It writes those words into the ROM through the ROM's write port. When the image is loaded it hands the ROM read path to the CPU instruction-fetch port and releases the CPU. It sits between the CPU fetch interface, the byte source and the rom instance.

Parameters:
ROM_WORDS, 24576, ROM capacity in 32-bit words; writes at or beyond this index are suppressed.
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word aligned).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active high (`RstEnable)
load_req_i  input  1  request re-load while in RUN
byte_valid_i  input  1  byte source has data
byte_data_i  input  8  stream byte
byte_ready_o  output  1  loader accepts byte this cycle
cpu_ce_i  input  1  CPU fetch enable
cpu_addr_i  input  `MemAddrBus  CPU fetch byte address
cpu_data_o  output  `MemBus  fetched instruction to CPU
cpu_rst_o  output  1  holds CPU in reset while loading
rom_we_o  output  1  ROM write enable (`WriteEnable)
rom_addr_o  output  `MemAddrBus  ROM byte address
rom_data_o  output  `MemBus  ROM write data
rom_data_i  input  `MemBus  ROM combinational read data
busy_o  output  1  high in every state except RUN
done_o  output  1  one-cycle pulse when load completes
err_o  output  1  sticky: length exceeded ROM_WORDS
words_o  output  32  words actually written in last/current load

Behaviour:
- Reset (synchronous, active high): state=LEN, byte count=0, word index=0, length=0, err_o=0, words_o=0, done_o=0. cpu_rst_o=1, busy_o=1, rom_we_o=0, cpu_data_o=`ZeroWord. ROM contents are untouched. Reset mid-load aborts the load and restarts at LEN.
- States: LEN, DATA, WRITE, DONE, RUN.
- Handshake: a byte transfers on a clock edge where byte_valid_i & byte_ready_o. byte_ready_o=1 in LEN and DATA only; it is 0 in WRITE, DONE and RUN. Bytes are packed little-endian: the first byte of each group goes to [7:0] and the fourth to [31:24].
- LEN: assemble 4 bytes into length N.
  - After the 4th byte: if N==0, go to DONE; else go to DATA.
  - err_o is set at this point if N>ROM_WORDS.
- DATA: assemble 4 bytes into the word register. After the 4th byte, go to WRITE.
- WRITE: lasts exactly one cycle.
  - If index<ROM_WORDS: rom_we_o=1, rom_addr_o=BASE_ADDR+4*index, rom_data_o=word, and words_o increments.
  - If index>=ROM_WORDS: rom_we_o=0, but the bytes are still consumed.
  - index increments. If the new index==N, go to DONE; else return to DATA.
- DONE: one cycle. done_o=1 and cpu_rst_o=1. Next state is RUN.
- RUN:
  - cpu_rst_o=0, busy_o=0, rom_we_o=0.
  - rom_addr_o=cpu_addr_i.
  - cpu_data_o=rom_data_i when cpu_ce_i=1, else `ZeroWord. This path is combinational, with zero added latency.
  - load_req_i=1 → next cycle goes to LEN. Counters and err_o clear and words_o resets to 0; cpu_rst_o rises in that same next cycle.
- In any state other than RUN, cpu_data_o=`ZeroWord. load_req_i is ignored outside RUN.
- Address arithmetic is 32-bit and wraps silently; the index counter is 32-bit.
- Outside WRITE and RUN, rom_addr_o=BASE_ADDR+4*index and rom_data_o=`ZeroWord.

Decomposition:
- Add the following to defines.v:
  - state encodings `LdLen, `LdData, `LdWrite, `LdDone, `LdRun
  - `ByteBus 7:0
  - reuse `MemBus, `MemAddrBus, `ZeroWord, `RstEnable, `WriteEnable
- One natural sub-module is byte_packer. It holds a 2-bit byte counter and a 32-bit shift/assemble register. It exposes a word_valid pulse and a clear input, and the FSM uses it for both the length and the data words.

Test Plan:
- Basic load: stream 02 00 00 00, 78 56 34 12, EF BE AD DE with continuous valid → required response:
  - exactly two rom_we_o pulses: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF
  - done_o pulses once and words_o=2
  - cpu_rst_o falls the cycle after DONE
  - in RUN, cpu_addr_i=0x4 with cpu_ce_i=1 returns 0xDEADBEEF in the same cycle.
- Zero length: stream 00 00 00 00 → no rom_we_o, LEN→DONE→RUN, words_o=0, err_o=0.
- Backpressure: insert random valid gaps, and hold valid high during WRITE → no byte lost or duplicated, byte_ready_o=0 in the WRITE cycle, data correct.
- Overflow with ROM_WORDS=4 and N=6 → err_o=1 after the length word, exactly 4 writes (0x0..0xC), all 24 data bytes consumed, done_o pulses, words_o=4.
- Reload: in RUN, pulse load_req_i and send N=1 with word 0xCAFEBABE → cpu_rst_o=1 the next cycle, addr 0x0 is rewritten, then RUN resumes. A load_req_i pulse during DATA has no effect.
- Reset mid-load: assert rst after 2 of 4 data bytes → state LEN, cpu_rst_o=1, words_o=0. A fresh full stream then loads correctly from BASE_ADDR.
